// File: rtl/spidac_rx_if.sv
// Command bus shared by the vjtag/eth controllers: address, write data, strobe and read return.
// The master drives addr/data/write; each slave returns data_out for the current addr.
interface spidac_rx_if;
   logic [7:0] addr;
   logic [7:0] data;
   logic       write;
   logic [7:0] data_out;

   modport master (output addr, output data, output write, input data_out);
   modport slave  (input addr, input data, input write, output data_out);
endinterface

// File: rtl/spidac_rx.sv
// Receiver and loopback monitor for the DAC serial link: oversamples SCK/nCS/SDI/nLDAC,
// deserialises 16-bit frames, models the DAC input/output latch pair and exposes status on the bus.
module spidac_rx #(
   parameter logic [7:0] BASE_ADDR  = 8'h30,
   parameter int         FRAME_BITS = 16
) (
   input  logic         clock50Mhz,
   input  logic         reset,
   spidac_rx_if.slave   bus,
   input  logic         SCK,
   input  logic         nCS,
   input  logic         SDI,
   input  logic         nLDAC,
   output logic [11:0]  dac_word,
   output logic [3:0]   dac_cfg,
   output logic         dac_update
);

   localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

   state_t      state_r, state_s;
   logic [2:0]  sck_sync_r, ncs_sync_r, ldac_sync_r;
   logic [1:0]  sdi_sync_r;
   logic [1:0]  rst_done_r;
   logic        armed_r;
   logic [4:0]  bit_cnt_r, last_cnt_r;
   logic [15:0] shift_r, latch_r, latch_next_s;
   logic        pending_r, pending_next_s;
   logic        err_len_r, err_ldac_r, overrun_r;
   logic [7:0]  frame_cnt_r;
   logic        sck_rise_s, ncs_fall_s, ncs_rise_s, ldac_fall_s;
   logic        start_s, shift_en_s, end_s, commit_s, len_err_s;
   logic        load_s, ldac_err_s, overrun_set_s;
   logic        wr_status_s, flag_clr_s, cnt_clr_s;
   logic [7:0]  offset_s, rd_data_s;
   logic        unused_s;

   // Two-flop synchronisers plus an edge-detect stage for every link pin
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         sck_sync_r  <= 3'b111;
         ncs_sync_r  <= 3'b111;
         ldac_sync_r <= 3'b111;
         sdi_sync_r  <= 2'b00;
      end else begin
         sck_sync_r  <= {sck_sync_r[1:0], SCK};
         ncs_sync_r  <= {ncs_sync_r[1:0], nCS};
         ldac_sync_r <= {ldac_sync_r[1:0], nLDAC};
         sdi_sync_r  <= {sdi_sync_r[0], SDI};
      end
   end

   // The synchronisers reset high, so an nCS held low across reset release would fake a
   // falling edge; chip-select falls only count once nCS has been seen high after reset.
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         rst_done_r <= 2'b00;
         armed_r    <= 1'b0;
      end else begin
         rst_done_r <= {rst_done_r[0], 1'b1};
         armed_r    <= armed_r | (rst_done_r[1] & ncs_sync_r[1]);
      end
   end

   assign sck_rise_s  = sck_sync_r[1] & ~sck_sync_r[2];
   assign ncs_fall_s  = ~ncs_sync_r[1] & ncs_sync_r[2] & armed_r;
   assign ncs_rise_s  = ncs_sync_r[1] & ~ncs_sync_r[2];
   assign ldac_fall_s = ~ldac_sync_r[1] & ldac_sync_r[2];

   assign wr_status_s = bus.write & (bus.addr == BASE_ADDR);
   assign flag_clr_s  = wr_status_s & bus.data[0];
   assign cnt_clr_s   = wr_status_s & bus.data[1];
   assign unused_s    = ^bus.data[7:2];

   // Serial FSM state register
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and frame-level strobes
   always_comb begin
      state_s    = state_r;
      start_s    = 1'b0;
      shift_en_s = 1'b0;
      end_s      = 1'b0;
      commit_s   = 1'b0;
      len_err_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = ncs_fall_s;
            if (ncs_fall_s) begin
               state_s = ST_SHIFT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_en_s = sck_rise_s;
            end_s      = ncs_rise_s;
            commit_s   = ncs_rise_s & (bit_cnt_r == FRAME_LEN);
            len_err_s  = ncs_rise_s & (bit_cnt_r != FRAME_LEN);
            if (ncs_rise_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // A commit is applied before a coincident load, so a simultaneous nLDAC takes the new frame
   always_comb begin
      latch_next_s   = latch_r;
      pending_next_s = pending_r;
      load_s         = 1'b0;
      ldac_err_s     = 1'b0;
      overrun_set_s  = commit_s & pending_r;
      if (commit_s) begin
         latch_next_s   = shift_r;
         pending_next_s = 1'b1;
      end else begin
         latch_next_s   = latch_r;
         pending_next_s = pending_r;
      end
      if (ldac_fall_s) begin
         if (pending_next_s) begin
            load_s         = 1'b1;
            pending_next_s = 1'b0;
         end else begin
            ldac_err_s = 1'b1;
         end
      end else begin
         load_s = 1'b0;
      end
   end

   // Shift register, bit counter and the input/output latch pair
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         shift_r    <= 16'h0000;
         bit_cnt_r  <= 5'd0;
         last_cnt_r <= 5'd0;
         latch_r    <= 16'h0000;
         pending_r  <= 1'b0;
         dac_word   <= 12'h000;
         dac_cfg    <= 4'h0;
         dac_update <= 1'b0;
      end else begin
         if (start_s) begin
            shift_r   <= 16'h0000;
            bit_cnt_r <= 5'd0;
         end else if (shift_en_s) begin
            shift_r <= {shift_r[14:0], sdi_sync_r[1]};
            if (bit_cnt_r != 5'd31) begin
               bit_cnt_r <= bit_cnt_r + 5'd1;
            end
         end
         if (end_s) begin
            last_cnt_r <= bit_cnt_r;
         end
         latch_r    <= latch_next_s;
         pending_r  <= pending_next_s;
         dac_update <= load_s;
         if (load_s) begin
            dac_cfg  <= latch_next_s[15:12];
            dac_word <= latch_next_s[11:0];
         end
      end
   end

   // Sticky error flags and frame counter; a set or increment beats a same-cycle clear
   always_ff @(posedge clock50Mhz or posedge reset) begin
      if (reset) begin
         err_len_r   <= 1'b0;
         err_ldac_r  <= 1'b0;
         overrun_r   <= 1'b0;
         frame_cnt_r <= 8'd0;
      end else begin
         err_len_r  <= len_err_s     | (err_len_r  & ~flag_clr_s);
         err_ldac_r <= ldac_err_s    | (err_ldac_r & ~flag_clr_s);
         overrun_r  <= overrun_set_s | (overrun_r  & ~flag_clr_s);
         if (cnt_clr_s) begin
            frame_cnt_r <= commit_s ? 8'd1 : 8'd0;
         end else if (commit_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
      end
   end

   assign offset_s = bus.addr - BASE_ADDR;

   // Register window read mux
   always_comb begin
      rd_data_s = 8'h00;
      case (offset_s)
         8'd0:    rd_data_s = {3'b000, ncs_sync_r[1], overrun_r, err_ldac_r, err_len_r, pending_r};
         8'd1:    rd_data_s = dac_word[7:0];
         8'd2:    rd_data_s = {dac_cfg, dac_word[11:8]};
         8'd3:    rd_data_s = frame_cnt_r;
         8'd4:    rd_data_s = {3'b000, last_cnt_r};
         default: rd_data_s = 8'h00;
      endcase
   end

   assign bus.data_out = rd_data_s;

endmodule

// File: tb/tb_spidac_rx.sv
// Directed bench for spidac_rx: drives SPI frames and nLDAC pulses, checks the modelled
// DAC latch, the update pulse and the register window against hand-computed values.
module tb_spidac_rx;

   localparam logic [7:0] BASE = 8'h30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        ncs = 1'b1;
   logic        sdi = 1'b0;
   logic        nldac = 1'b1;
   logic [11:0] dac_word;
   logic [3:0]  dac_cfg;
   logic        dac_update;

   int checks   = 0;
   int failures = 0;
   int upd_cnt  = 0;
   int u0;

   spidac_rx_if bus_if ();

   spidac_rx #(.BASE_ADDR(BASE), .FRAME_BITS(16)) dut (
      .clock50Mhz (clk),
      .reset      (rst),
      .bus        (bus_if.slave),
      .SCK        (sck),
      .nCS        (ncs),
      .SDI        (sdi),
      .nLDAC      (nldac),
      .dac_word   (dac_word),
      .dac_cfg    (dac_cfg),
      .dac_update (dac_update)
   );

   always #10 clk = ~clk;

   // Count clocks with dac_update high, sampled mid-cycle
   always @(negedge clk) begin
      if (dac_update) upd_cnt++;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_if.addr = a;
      #5;
      d = bus_if.data_out;
      #5;
      check(tag, {8'h00, d}, {8'h00, exp});
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus_if.addr  = a;
      bus_if.data  = d;
      bus_if.write = 1'b1;
      @(posedge clk);
      #3;
      bus_if.write = 1'b0;
      bus_if.data  = 8'h00;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input int half);
      ncs = 1'b0;
      #200;
      for (int i = 0; i < n; i++) begin
         sdi = w[15 - i];
         #(half) sck = 1'b1;
         #(half) sck = 1'b0;
      end
   endtask

   task automatic frame(input logic [15:0] w, input int n, input int half);
      send_bits(w, n, half);
      #100 ncs = 1'b1;
      #200;
   endtask

   task automatic pulse_ldac();
      nldac = 1'b0;
      #100 nldac = 1'b1;
      #200;
   endtask

   initial begin
      bus_if.addr  = 8'h00;
      bus_if.data  = 8'h00;
      bus_if.write = 1'b0;
      #53 rst = 1'b0;
      #200;

      // reset state
      check("rst_word", {4'h0, dac_word}, 16'h0000);
      check("rst_cfg", {12'h000, dac_cfg}, 16'h0000);
      check("rst_upd", {15'h0000, dac_update}, 16'h0000);
      chk_rd("rst_status", BASE, 8'h10);
      chk_rd("rst_fcnt", BASE + 8'd3, 8'h00);

      // basic frame and load
      u0 = upd_cnt;
      frame(16'h3A5C, 16, 100);
      chk_rd("f1_pending", BASE, 8'h11);
      pulse_ldac();
      check("f1_cfg", {12'h000, dac_cfg}, 16'h0003);
      check("f1_word", {4'h0, dac_word}, 16'h0A5C);
      check("f1_upd", 16'(upd_cnt - u0), 16'd1);
      chk_rd("f1_rd1", BASE + 8'd1, 8'h5C);
      chk_rd("f1_rd2", BASE + 8'd2, 8'h3A);
      chk_rd("f1_rd3", BASE + 8'd3, 8'h01);
      chk_rd("f1_status", BASE, 8'h10);
      chk_rd("out_of_window", BASE + 8'd5, 8'h00);

      // short frame
      frame(16'h1234, 15, 100);
      chk_rd("short_status", BASE, 8'h12);
      chk_rd("short_last", BASE + 8'd4, 8'h0F);
      check("short_word", {4'h0, dac_word}, 16'h0A5C);
      wr(BASE + 8'd3, 8'h03);
      chk_rd("wr_ro_fcnt", BASE + 8'd3, 8'h01);
      wr(BASE, 8'h01);
      chk_rd("clr_status", BASE, 8'h10);

      // nLDAC without pending, then overrun
      u0 = upd_cnt;
      pulse_ldac();
      chk_rd("ldac_err", BASE, 8'h14);
      check("ldac_noupd", 16'(upd_cnt - u0), 16'd0);
      check("ldac_hold", {4'h0, dac_word}, 16'h0A5C);
      frame(16'h1111, 16, 100);
      frame(16'h2222, 16, 100);
      pulse_ldac();
      check("ovr_word", {4'h0, dac_word}, 16'h0222);
      check("ovr_cfg", {12'h000, dac_cfg}, 16'h0002);
      chk_rd("ovr_status", BASE, 8'h1C);
      chk_rd("ovr_fcnt", BASE + 8'd3, 8'h03);
      wr(BASE, 8'h01);
      chk_rd("ovr_clr", BASE, 8'h10);

      // nCS rise and nLDAC fall in the same instant
      u0 = upd_cnt;
      send_bits(16'hF00F, 16, 100);
      #100;
      ncs   = 1'b1;
      nldac = 1'b0;
      #100 nldac = 1'b1;
      #200;
      check("sim_word", {4'h0, dac_word}, 16'h000F);
      check("sim_cfg", {12'h000, dac_cfg}, 16'h000F);
      chk_rd("sim_status", BASE, 8'h10);
      check("sim_upd", 16'(upd_cnt - u0), 16'd1);
      chk_rd("sim_fcnt", BASE + 8'd3, 8'h04);

      // reset mid-frame
      ncs = 1'b0;
      #200;
      for (int i = 0; i < 8; i++) begin
         sdi = i[0];
         #100 sck = 1'b1;
         #100 sck = 1'b0;
      end
      rst = 1'b1;
      #40 ncs = 1'b1;
      #100 rst = 1'b0;
      #200;
      chk_rd("mid_status", BASE, 8'h10);
      chk_rd("mid_fcnt", BASE + 8'd3, 8'h00);
      chk_rd("mid_last", BASE + 8'd4, 8'h00);
      check("mid_word", {4'h0, dac_word}, 16'h0000);
      frame(16'h0ABC, 16, 100);
      chk_rd("post_fcnt", BASE + 8'd3, 8'h01);
      chk_rd("post_status", BASE, 8'h11);
      pulse_ldac();
      check("post_word", {4'h0, dac_word}, 16'h0ABC);
      chk_rd("post_rd2", BASE + 8'd2, 8'h0A);

      // frame counter wrap
      wr(BASE, 8'h02);
      chk_rd("wrap_clr", BASE + 8'd3, 8'h00);
      for (int i = 0; i < 255; i++) begin
         frame(16'(i * 16'h0101), 16, 60);
      end
      chk_rd("wrap_ff", BASE + 8'd3, 8'hFF);
      frame(16'h5A5A, 16, 60);
      chk_rd("wrap_00", BASE + 8'd3, 8'h00);

      // counter clear coincident with a commit
      send_bits(16'h5555, 16, 100);
      #100 ncs = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      wr(BASE, 8'h02);
      #200;
      chk_rd("clr_commit", BASE + 8'd3, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
